// File: rtl/hilo_ctrl.sv
// HI/LO register owner and MULT_DIV sequencer: accepts mul/div/move requests,
// launches MULT_DIV, captures its {hi,lo} result and stalls the requester while busy.
module hilo_ctrl #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned START_LAT = 1,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic [2:0]            req_op,
    input  logic [DATA_W-1:0]     rs_val,
    input  logic [DATA_W-1:0]     rt_val,
    output logic                  req_ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  md_enable,
    output logic [DATA_W-1:0]     md_value_1,
    output logic [DATA_W-1:0]     md_value_2,
    output logic [1:0]            md_operation,
    input  logic [2*DATA_W-1:0]   md_out,
    input  logic                  md_in_operation,
    output logic [DATA_W-1:0]     hi,
    output logic [DATA_W-1:0]     lo,
    output logic                  err
);

    localparam int unsigned CNT_MAX = (TIMEOUT > START_LAT) ? TIMEOUT : START_LAT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_DONE
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                req_ready_nxt;
    logic                rd_valid_nxt;
    logic [DATA_W-1:0]   rd_data_nxt;
    logic                md_enable_nxt;
    logic [DATA_W-1:0]   md_value_1_nxt;
    logic [DATA_W-1:0]   md_value_2_nxt;
    logic [1:0]          md_operation_nxt;
    logic [DATA_W-1:0]   hi_nxt;
    logic [DATA_W-1:0]   lo_nxt;
    logic                err_nxt;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        rd_valid_nxt     = 1'b0;
        rd_data_nxt      = rd_data;
        md_enable_nxt    = 1'b0;
        md_value_1_nxt   = md_value_1;
        md_value_2_nxt   = md_value_2;
        md_operation_nxt = md_operation;
        hi_nxt           = hi;
        lo_nxt           = lo;
        err_nxt          = err;

        case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    if (!req_op[2]) begin
                        md_value_1_nxt   = rs_val;
                        md_value_2_nxt   = rt_val;
                        md_operation_nxt = req_op[1:0];
                        md_enable_nxt    = 1'b1;
                        cnt_nxt          = '0;
                        state_nxt        = S_LAUNCH;
                    end else begin
                        case (req_op[1:0])
                            2'd0: begin
                                rd_valid_nxt = 1'b1;
                                rd_data_nxt  = hi;
                            end
                            2'd1: begin
                                rd_valid_nxt = 1'b1;
                                rd_data_nxt  = lo;
                            end
                            2'd2:    hi_nxt = rs_val;
                            default: lo_nxt = rs_val;
                        endcase
                    end
                end
            end
            S_LAUNCH: begin
                // md_in_operation is not trusted until START_LAT cycles after the pulse
                if (cnt == CNT_W'(START_LAT - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (!md_in_operation) begin
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    if ((TIMEOUT != 0) && (cnt_nxt == CNT_W'(TIMEOUT))) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DONE: begin
                hi_nxt    = md_out[2*DATA_W-1:DATA_W];
                lo_nxt    = md_out[DATA_W-1:0];
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        req_ready_nxt = (state_nxt == S_IDLE);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Output and architectural registers; req_ready comes out of reset high since IDLE accepts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= 1'b1;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            md_enable    <= 1'b0;
            md_value_1   <= '0;
            md_value_2   <= '0;
            md_operation <= '0;
            hi           <= '0;
            lo           <= '0;
            err          <= 1'b0;
        end else begin
            req_ready    <= req_ready_nxt;
            rd_valid     <= rd_valid_nxt;
            rd_data      <= rd_data_nxt;
            md_enable    <= md_enable_nxt;
            md_value_1   <= md_value_1_nxt;
            md_value_2   <= md_value_2_nxt;
            md_operation <= md_operation_nxt;
            hi           <= hi_nxt;
            lo           <= lo_nxt;
            err          <= err_nxt;
        end
    end

endmodule
